// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the multi-digit 7-segment driver.
// Glyphs are active-low {g,f,e,d,c,b,a}; a cleared bit lights that segment.
package seg7_pkg;

  typedef logic [7:0] char_t;
  typedef logic [7:0] seg_t;

  localparam char_t CH_OFF  = 8'd127;
  localparam seg_t  SEG_OFF = 8'hFF;

  localparam logic [6:0] GLY_0   = 7'h40;
  localparam logic [6:0] GLY_1   = 7'h79;
  localparam logic [6:0] GLY_2   = 7'h24;
  localparam logic [6:0] GLY_3   = 7'h30;
  localparam logic [6:0] GLY_4   = 7'h19;
  localparam logic [6:0] GLY_5   = 7'h12;
  localparam logic [6:0] GLY_6   = 7'h02;
  localparam logic [6:0] GLY_7   = 7'h78;
  localparam logic [6:0] GLY_8   = 7'h00;
  localparam logic [6:0] GLY_9   = 7'h10;
  localparam logic [6:0] GLY_A   = 7'h08;
  localparam logic [6:0] GLY_B   = 7'h03;
  localparam logic [6:0] GLY_C   = 7'h46;
  localparam logic [6:0] GLY_D   = 7'h21;
  localparam logic [6:0] GLY_E   = 7'h06;
  localparam logic [6:0] GLY_F   = 7'h0E;
  localparam logic [6:0] GLY_I   = 7'h79;
  localparam logic [6:0] GLY_N   = 7'h2B;
  localparam logic [6:0] GLY_O   = 7'h40;
  localparam logic [6:0] GLY_P   = 7'h0C;
  localparam logic [6:0] GLY_S   = 7'h12;
  localparam logic [6:0] GLY_T   = 7'h07;
  localparam logic [6:0] GLY_X   = 7'h09;
  localparam logic [6:0] GLY_OFF = 7'h7F;

endpackage

// File: rtl/seg7_glyph.sv
// Character code to 7-segment pattern; purely combinational.
// Hex digits use codes 0-15, a few letters use their ASCII codes, all else is blank.
module seg7_glyph
  import seg7_pkg::*;
(
  input  char_t      code,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLY_OFF;
    case (code)
      8'd0:  seg = GLY_0;
      8'd1:  seg = GLY_1;
      8'd2:  seg = GLY_2;
      8'd3:  seg = GLY_3;
      8'd4:  seg = GLY_4;
      8'd5:  seg = GLY_5;
      8'd6:  seg = GLY_6;
      8'd7:  seg = GLY_7;
      8'd8:  seg = GLY_8;
      8'd9:  seg = GLY_9;
      8'd10: seg = GLY_A;
      8'd11: seg = GLY_B;
      8'd12: seg = GLY_C;
      8'd13: seg = GLY_D;
      8'd14: seg = GLY_E;
      8'd15: seg = GLY_F;
      8'd65: seg = GLY_A;
      8'd67: seg = GLY_C;
      8'd68: seg = GLY_D;
      8'd73: seg = GLY_I;
      8'd78: seg = GLY_N;
      8'd79: seg = GLY_O;
      8'd80: seg = GLY_P;
      8'd83: seg = GLY_S;
      8'd84: seg = GLY_T;
      8'd88: seg = GLY_X;
      default: seg = GLY_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_display.sv
// Multi-digit HEX driver: shadowed static text with blink/dp, scrolling buffer text,
// and PWM dimming. Every led bit comes straight from a register.
module seg7_display
  import seg7_pkg::*;
#(
  parameter int NDIGITS    = 6,
  parameter int BUF_DEPTH  = 16,
  parameter int BLINK_DIV  = 12_500_000,
  parameter int SCROLL_DIV = 12_500_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         upd,
  input  logic [NDIGITS*8-1:0]         chars,
  input  logic [NDIGITS-1:0]           dp,
  input  logic [NDIGITS-1:0]           blink,
  input  logic                         mode,
  input  logic                         wr_en,
  input  logic [$clog2(BUF_DEPTH)-1:0] wr_addr,
  input  logic [7:0]                   wr_data,
  input  logic [$clog2(BUF_DEPTH):0]   scroll_len,
  input  logic [3:0]                   bright,
  output logic [NDIGITS*8-1:0]         led
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int SW = $clog2(SCROLL_DIV + 1);

  logic [NDIGITS*8-1:0] sh_chars_reg;
  logic [NDIGITS-1:0]   sh_dp_reg;
  logic [NDIGITS-1:0]   sh_blink_reg;
  char_t                scroll_buf_reg [BUF_DEPTH];
  logic [BW-1:0]        bcnt_reg;
  logic                 phase_reg;
  logic [SW-1:0]        scnt_reg, scnt_next;
  logic [AW-1:0]        pos_reg, pos_next;
  logic                 mode_reg;
  logic [3:0]           pwm_reg;
  logic [NDIGITS*8-1:0] led_reg, led_next;

  logic blink_tick, scroll_tick, pwm_on, len_zero;

  assign blink_tick  = (bcnt_reg == BW'(BLINK_DIV - 1));
  assign scroll_tick = (scnt_reg == SW'(SCROLL_DIV - 1));
  assign pwm_on      = (bright == 4'hF) || (pwm_reg < bright);
  assign len_zero    = (scroll_len == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_chars_reg <= {NDIGITS{CH_OFF}};
      sh_dp_reg    <= '0;
      sh_blink_reg <= '0;
    end else if (upd) begin
      sh_chars_reg <= chars;
      sh_dp_reg    <= dp;
      sh_blink_reg <= blink;
    end
  end

  // Register array rather than RAM: every digit reads it in parallel and it must reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) scroll_buf_reg[i] <= CH_OFF;
    end else if (wr_en) begin
      scroll_buf_reg[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_reg  <= '0;
      phase_reg <= 1'b0;
      pwm_reg   <= '0;
    end else begin
      bcnt_reg  <= blink_tick ? '0 : bcnt_reg + BW'(1);
      phase_reg <= phase_reg ^ blink_tick;
      pwm_reg   <= pwm_reg + 4'd1;
    end
  end

  // A mode change restarts scrolling; a shrunk or empty buffer pulls pos back to 0.
  always_comb begin
    scnt_next = scnt_reg;
    pos_next  = pos_reg;
    if (mode != mode_reg) begin
      scnt_next = '0;
      pos_next  = '0;
    end else begin
      if (mode) scnt_next = scroll_tick ? '0 : scnt_reg + SW'(1);
      if (len_zero || ({1'b0, pos_reg} >= scroll_len))
        pos_next = '0;
      else if (mode && scroll_tick)
        pos_next = ({1'b0, pos_reg} == scroll_len - LW'(1)) ? '0 : pos_reg + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_reg <= '0;
      pos_reg  <= '0;
      mode_reg <= 1'b0;
    end else begin
      scnt_reg <= scnt_next;
      pos_reg  <= pos_next;
      mode_reg <= mode;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_digit
      logic [AW-1:0] rd_idx;
      char_t         code;
      logic [6:0]    seg;
      logic          hide;

      always_comb begin
        rd_idx = '0;
        if (!len_zero)
          rd_idx = AW'((32'(pos_reg) + 32'(NDIGITS - 1 - gi)) % 32'(scroll_len));
        code = mode ? scroll_buf_reg[rd_idx] : sh_chars_reg[gi*8 +: 8];
      end

      seg7_glyph u_glyph (
        .code (code),
        .seg  (seg)
      );

      assign hide = !pwm_on || (mode && len_zero) || (!mode && phase_reg && sh_blink_reg[gi]);
      assign led_next[gi*8 +: 8] = hide ? SEG_OFF : seg_t'({!(sh_dp_reg[gi] && !mode), seg});
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_reg <= {NDIGITS{SEG_OFF}};
    else        led_reg <= led_next;
  end

  assign led = led_reg;

endmodule
